// File: rtl/bg_fetch_ctrl.sv
// Background tile fetcher: once per scanline walks the BG map, reads tile index and
// both bitplane bytes from VRAM, and streams 8 two-bit pixels per tile into the BG FIFO.
module bg_fetch_ctrl #(
  parameter int TILES_PER_LINE = 21,
  parameter int VRAM_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic        lcdc_bg_map_sel,
  input  logic        lcdc_tile_sel,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  output logic        vram_read_req,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_rdata,
  output logic        fifo_write_en,
  output logic [1:0]  fifo_write_data,
  input  logic        fifo_full,
  output logic        busy,
  output logic        line_done
);

  localparam int IW = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;

  // The WAIT states assume read data arrives exactly one cycle after the strobe.
  if (VRAM_LATENCY != 1) begin : g_bad_latency
    $error("bg_fetch_ctrl supports VRAM_LATENCY == 1 only");
  end

  typedef enum logic [3:0] {
    IDLE, MAP_REQ, MAP_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, PUSH, DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] tile_idx;
  logic [2:0]    p;
  logic [7:0]    y_q;
  logic [4:0]    x0_q;
  logic          map_sel_q;
  logic          tile_sel_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;

  logic [7:0]    y_now;
  logic [4:0]    col_next;
  logic [2:0]    pix_bit;
  logic          last_tile;
  logic          in_push;

  function automatic logic [15:0] map_addr(input logic sel, input logic [7:0] y,
                                           input logic [4:0] col);
    logic [15:0] base;
    base = sel ? 16'h9C00 : 16'h9800;
    return base + {6'd0, y[7:3], 5'd0} + {11'd0, col};
  endfunction

  function automatic logic [15:0] lo_addr(input logic tsel, input logic [7:0] tn,
                                          input logic [2:0] row);
    logic [15:0] a;
    if (tsel) a = 16'h8000 + {4'd0, tn, 4'd0};
    else      a = 16'h9000 + {{4{tn[7]}}, tn, 4'd0};
    return a + {12'd0, row, 1'b0};
  endfunction

  assign y_now     = ly + scy;
  assign col_next  = x0_q + 5'(tile_idx) + 5'd1;
  assign last_tile = (tile_idx == IW'(TILES_PER_LINE - 1));
  assign pix_bit   = 3'd7 - p;
  assign in_push   = (state == PUSH);

  // FIFO handshake: a pixel transfers in any PUSH cycle where fifo_full is low; the
  // write is suppressed in a line_start (abort) cycle so no stray pixel escapes.
  assign fifo_write_en   = in_push && !fifo_full && !line_start;
  assign fifo_write_data = in_push ? {hi_q[pix_bit], lo_q[pix_bit]} : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tile_idx      <= '0;
      p             <= '0;
      y_q           <= '0;
      x0_q          <= '0;
      map_sel_q     <= 1'b0;
      tile_sel_q    <= 1'b0;
      lo_q          <= '0;
      hi_q          <= '0;
      vram_read_req <= 1'b0;
      vram_addr     <= '0;
      busy          <= 1'b0;
      line_done     <= 1'b0;
    end else if (line_start) begin
      // Start (or restart) a line from tile 0 with freshly latched parameters.
      state         <= MAP_REQ;
      tile_idx      <= '0;
      p             <= '0;
      y_q           <= y_now;
      x0_q          <= scx[7:3];
      map_sel_q     <= lcdc_bg_map_sel;
      tile_sel_q    <= lcdc_tile_sel;
      vram_read_req <= 1'b1;
      vram_addr     <= map_addr(lcdc_bg_map_sel, y_now, scx[7:3]);
      busy          <= 1'b1;
      line_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vram_read_req <= 1'b0;
        end
        MAP_REQ: begin
          state         <= MAP_WAIT;
          vram_read_req <= 1'b0;
        end
        MAP_WAIT: begin
          // The tile number is only needed to form the bitplane address.
          state         <= LO_REQ;
          vram_read_req <= 1'b1;
          vram_addr     <= lo_addr(tile_sel_q, vram_rdata, y_q[2:0]);
        end
        LO_REQ: begin
          state         <= LO_WAIT;
          vram_read_req <= 1'b0;
        end
        LO_WAIT: begin
          lo_q          <= vram_rdata;
          state         <= HI_REQ;
          vram_read_req <= 1'b1;
          vram_addr     <= vram_addr + 16'd1;
        end
        HI_REQ: begin
          state         <= HI_WAIT;
          vram_read_req <= 1'b0;
        end
        HI_WAIT: begin
          hi_q  <= vram_rdata;
          p     <= '0;
          state <= PUSH;
        end
        PUSH: begin
          if (!fifo_full) begin
            p <= p + 3'd1;
            if (p == 3'd7) begin
              if (last_tile) begin
                state     <= DONE;
                line_done <= 1'b1;
                busy      <= 1'b0;
              end else begin
                tile_idx      <= tile_idx + 1'b1;
                state         <= MAP_REQ;
                vram_read_req <= 1'b1;
                vram_addr     <= map_addr(map_sel_q, y_q, col_next);
              end
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          line_done <= 1'b0;
          tile_idx  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bg_fetch_ctrl.sv
// Self-checking bench for bg_fetch_ctrl: a VRAM model answers reads, a scoreboard
// predicts every read address and pushed pixel, scenario tasks check timing.
module tb_bg_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        line_start = 1'b0;
  logic        msel = 1'b0;
  logic        tsel = 1'b1;
  logic [7:0]  scx = '0;
  logic [7:0]  scy = '0;
  logic [7:0]  ly = '0;
  logic        vram_read_req;
  logic [15:0] vram_addr;
  logic [7:0]  vram_rdata = '0;
  logic        fifo_write_en;
  logic [1:0]  fifo_write_data;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        line_done;

  int tests_run = 0;
  int tests_failed = 0;
  int ld_count = 0;

  logic [15:0] addr_q[$];
  logic [1:0]  exp_q[$];
  logic [15:0] mon_a;
  logic [1:0]  mon_p;
  logic [7:0]  vram [0:65535];

  always #5 clk = ~clk;

  bg_fetch_ctrl #(.TILES_PER_LINE(21), .VRAM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start),
    .lcdc_bg_map_sel(msel), .lcdc_tile_sel(tsel),
    .scx(scx), .scy(scy), .ly(ly),
    .vram_read_req(vram_read_req), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fifo_full(fifo_full), .busy(busy), .line_done(line_done)
  );

  // VRAM model: data for a request is presented during the following cycle.
  always @(posedge clk) if (vram_read_req === 1'b1) vram_rdata <= vram[vram_addr];

  // Scoreboard: every read address and every pushed pixel is popped in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vram_read_req || fifo_write_en) begin
        tests_run++;
        if (vram_read_req && fifo_write_en) begin
          tests_failed++;
          $display("FAIL excl: read_req=%b write_en=%b both high, required not both", vram_read_req, fifo_write_en);
        end
      end
      if (vram_read_req) begin
        tests_run++;
        if (addr_q.size() == 0) begin
          tests_failed++;
          $display("FAIL read_addr: got read of %h, required no read", vram_addr);
        end else begin
          mon_a = addr_q.pop_front();
          if (vram_addr !== mon_a) begin
            tests_failed++;
            $display("FAIL read_addr: got %h, required %h", vram_addr, mon_a);
          end
        end
      end
      if (fifo_write_en) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL pixel: got push of %0d, required no push", fifo_write_data);
        end else begin
          mon_p = exp_q.pop_front();
          if (fifo_write_data !== mon_p) begin
            tests_failed++;
            $display("FAIL pixel: got %0d, required %0d", fifo_write_data, mon_p);
          end
        end
      end
      if (line_done === 1'b1) ld_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected read addresses and pixels for a line, in integer math.
  function automatic void predict(input logic [7:0] l, input logic [7:0] sy, input logic [7:0] sx,
                                  input logic ms, input logic ts, input int ntiles, input bit extra_map);
    int y, x0, row, m, tn, lo, n;
    logic [7:0] lb, hb;
    y   = (int'(l) + int'(sy)) % 256;
    x0  = int'(sx) / 8;
    row = y % 8;
    n   = ntiles + (extra_map ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      m = (ms ? 'h9C00 : 'h9800) + (y / 8) * 32 + ((x0 + i) % 32);
      addr_q.push_back(16'(m));
      if (i < ntiles) begin
        tn = int'(vram[m]);
        if (!ts && tn >= 128) tn = tn - 256;
        lo = ((ts ? 'h8000 : 'h9000) + tn * 16 + row * 2) & 'hFFFF;
        addr_q.push_back(16'(lo));
        addr_q.push_back(16'(lo + 1));
        lb = vram[lo];
        hb = vram[lo + 1];
        for (int b = 7; b >= 0; b--) exp_q.push_back({hb[b], lb[b]});
      end
    end
  endfunction

  // Pulses line_start in the current cycle; returns in cycle 1 of the new line with
  // the line parameters scrambled to show that they are latched.
  task automatic start_line(input logic [7:0] l, input logic [7:0] sy, input logic [7:0] sx,
                            input logic ms, input logic ts, input int ntiles, input bit extra_map);
    ly = l; scy = sy; scx = sx; msel = ms; tsel = ts;
    line_start = 1'b1;
    predict(l, sy, sx, ms, ts, ntiles, extra_map);
    tick();
    line_start = 1'b0;
    ly = 8'($urandom_range(0, 255)); scy = 8'($urandom_range(0, 255));
    scx = 8'($urandom_range(0, 255)); msel = ~ms; tsel = ~ts;
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (line_done !== 1'b1 && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vram_read_req, vram_addr, fifo_write_en, fifo_write_data, busy, line_done} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b addr=%h we=%b data=%0d busy=%b done=%b, required all 0",
               vram_read_req, vram_addr, fifo_write_en, fifo_write_data, busy, line_done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tests_run++;
    if ({vram_read_req, fifo_write_en, busy, line_done} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got req=%b we=%b busy=%b done=%b, required 0", vram_read_req, fifo_write_en, busy, line_done);
    end
  endtask

  task automatic test_first_tile();
    logic [1:0] pix [8];
    int cnt;
    pix[0] = 2'd1; pix[1] = 2'd0; pix[2] = 2'd3; pix[3] = 2'd2;
    pix[4] = 2'd2; pix[5] = 2'd3; pix[6] = 2'd0; pix[7] = 2'd1;
    vram[16'h9800] = 8'h05; vram[16'h8050] = 8'hA5; vram[16'h8051] = 8'h3C;
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 21, 1'b0);
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h9800 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_map: got req=%b addr=%h busy=%b, required 1 9800 1", vram_read_req, vram_addr, busy);
    end
    tick();
    tests_run++;
    if (vram_read_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_wait: got req=%b, required 0", vram_read_req);
    end
    tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h8050) begin
      tests_failed++;
      $display("FAIL first_lo: got req=%b addr=%h, required 1 8050", vram_read_req, vram_addr);
    end
    repeat (2) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h8051) begin
      tests_failed++;
      $display("FAIL first_hi: got req=%b addr=%h, required 1 8051", vram_read_req, vram_addr);
    end
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (fifo_write_en !== 1'b1 || fifo_write_data !== pix[i]) begin
        tests_failed++;
        $display("FAIL first_push%0d: got we=%b data=%0d, required 1 %0d", i, fifo_write_en, fifo_write_data, pix[i]);
      end
      tick();
    end
    wait_done(400, cnt);
    tick();
    tests_run++;
    if (cnt >= 400 || addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL first_line_end: got wait=%0d reads_left=%0d pixels_left=%0d, required done and 0 0", cnt, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_signed();
    int cnt;
    vram[16'h9800] = 8'h80;
    start_line(8'd3, 8'd0, 8'd0, 1'b0, 1'b0, 21, 1'b0);
    repeat (2) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h8806) begin
      tests_failed++;
      $display("FAIL signed_lo: got req=%b addr=%h, required 1 8806", vram_read_req, vram_addr);
    end
    repeat (2) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h8807) begin
      tests_failed++;
      $display("FAIL signed_hi: got req=%b addr=%h, required 1 8807", vram_read_req, vram_addr);
    end
    wait_done(400, cnt);
    tick();
    tests_run++;
    if (cnt >= 400 || addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL signed_line_end: got wait=%0d reads_left=%0d pixels_left=%0d, required done and 0 0", cnt, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int cnt;
    start_line(8'd10, 8'd250, 8'hF8, 1'b1, 1'b1, 21, 1'b0);
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h9C1F) begin
      tests_failed++;
      $display("FAIL wrap_tile0: got req=%b addr=%h, required 1 9c1f", vram_read_req, vram_addr);
    end
    repeat (14) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h9C00) begin
      tests_failed++;
      $display("FAIL wrap_tile1: got req=%b addr=%h, required 1 9c00", vram_read_req, vram_addr);
    end
    wait_done(400, cnt);
    tick();
    tests_run++;
    if (cnt >= 400 || addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_line_end: got wait=%0d reads_left=%0d pixels_left=%0d, required done and 0 0", cnt, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 21, 1'b0);
    repeat (9) tick();
    tests_run++;
    if (fifo_write_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_p3: got we=%b, required 1", fifo_write_en);
    end
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      tests_run++;
      if (fifo_write_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: got we=%b, required 0", i, fifo_write_en);
      end
    end
    tick();
    fifo_full = 1'b0;
    #1;
    tests_run++;
    if (fifo_write_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_resume: got we=%b, required 1", fifo_write_en);
    end
    repeat (4) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h9801) begin
      tests_failed++;
      $display("FAIL bp_tile_time: got req=%b addr=%h at cycle 18, required 1 9801", vram_read_req, vram_addr);
    end
    wait_done(400, cnt);
    tests_run++;
    if (cnt != 280) begin
      tests_failed++;
      $display("FAIL bp_line_len: got done %0d cycles after cycle 18, required 280", cnt);
    end
    tick();
    tests_run++;
    if (addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_drain: got reads_left=%0d pixels_left=%0d, required 0 0", addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_full_line();
    int cnt;
    start_line(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 21, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_busy: got %b, required 1", busy);
    end
    wait_done(400, cnt);
    tests_run++;
    if (cnt != 21 * 14 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_done: got done %0d cycles after busy rose, busy=%b, required %0d and 0", cnt, busy, 21 * 14);
    end
    tick();
    tests_run++;
    if (line_done !== 1'b0 || busy !== 1'b0 || addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL full_after: got done=%b busy=%b reads_left=%0d pixels_left=%0d, required 0 0 0 0",
               line_done, busy, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_abort();
    int cnt, ld0;
    start_line(8'd20, 8'd5, 8'h30, 1'b0, 1'b1, 5, 1'b1);
    ld0 = ld_count;
    repeat (70) tick();
    tests_run++;
    if (vram_read_req !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_tile5: got req=%b busy=%b, required 1 1", vram_read_req, busy);
    end
    start_line(8'd100, 8'd0, 8'h10, 1'b1, 1'b0, 21, 1'b0);
    tests_run++;
    if (vram_read_req !== 1'b1 || vram_addr !== 16'h9D82) begin
      tests_failed++;
      $display("FAIL abort_restart: got req=%b addr=%h, required 1 9d82", vram_read_req, vram_addr);
    end
    wait_done(400, cnt);
    tests_run++;
    if (cnt != 21 * 14) begin
      tests_failed++;
      $display("FAIL abort_line_len: got %0d, required %0d", cnt, 21 * 14);
    end
    tick();
    tests_run++;
    if (ld_count - ld0 != 1 || addr_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_done_count: got %0d pulses reads_left=%0d pixels_left=%0d, required 1 0 0",
               ld_count - ld0, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_push();
    bit bad;
    start_line(8'd7, 8'd1, 8'd0, 1'b0, 1'b1, 21, 1'b0);
    repeat (8) tick();
    tests_run++;
    if (fifo_write_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: got we=%b, required 1", fifo_write_en);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vram_read_req, vram_addr, fifo_write_en, fifo_write_data, busy, line_done} !== 21'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got req=%b addr=%h we=%b data=%0d busy=%b done=%b, required all 0",
               vram_read_req, vram_addr, fifo_write_en, fifo_write_data, busy, line_done);
    end
    addr_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fifo_write_en !== 1'b0 || vram_read_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rst_quiet: got activity after reset release, required none");
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) vram[a] = 8'($urandom_range(0, 255));
    test_reset();
    test_first_tile();
    test_signed();
    test_wrap();
    test_backpressure();
    test_full_line();
    test_abort();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
